// File: rtl/uart_rx_dec.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling deframer and
// valid/ready byte delivery with interrupt pulse and sticky error flags.
module uart_rx_dec #(
   parameter int CLKS_PER_BIT = 434,
   parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       uart_dec,
   input  logic       rx_ready,
   input  logic       err_clr,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_int,
   output logic       busy,
   output logic       frame_err,
   output logic       overrun
);

   // Handshake: a byte is transferred in any cycle where rx_valid and rx_ready
   // are both high; rx_valid holds, with rx_data stable, until that happens.

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_TC = CW'(HALF_BIT - 1);
   localparam logic [CW-1:0] BIT_TC  = CW'(CLKS_PER_BIT - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic          sync1;
   logic          rx_s;
   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          stop_tc;
   logic          load;
   logic          drop;
   logic          ferr;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         sync1 <= uart_dec;
         rx_s  <= sync1;
      end
   end

   // Stop-bit decision is taken at mid-stop so a back-to-back start edge is seen.
   assign stop_tc = (state == STOP) && (cnt == BIT_TC);
   assign load    = stop_tc && rx_s && (!rx_valid || rx_ready);
   assign drop    = stop_tc && rx_s && rx_valid && !rx_ready;
   assign ferr    = stop_tc && !rx_s;
   assign busy    = (state != IDLE);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= 3'd0;
         shreg   <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state <= START;
                  cnt   <= '0;
               end
            end
            START: begin
               if (cnt == HALF_TC) begin
                  cnt     <= '0;
                  bit_idx <= 3'd0;
                  state   <= rx_s ? IDLE : DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == BIT_TC) begin
                  cnt   <= '0;
                  shreg <= {rx_s, shreg[7:1]};
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               if (cnt == BIT_TC) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         rx_int    <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         rx_int <= load;
         if (load) begin
            rx_data  <= shreg;
            rx_valid <= 1'b1;
         end else if (rx_ready) begin
            rx_valid <= 1'b0;
         end
         // A new error event takes priority over a simultaneous clear.
         if (ferr) begin
            frame_err <= 1'b1;
         end else if (err_clr) begin
            frame_err <= 1'b0;
         end
         if (drop) begin
            overrun <= 1'b1;
         end else if (err_clr) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_dec.sv
// Directed bench for uart_rx_dec: frames are driven bit by bit, expected bytes
// and their load cycle are queued at the start bit and matched on rx_int.
module tb_uart_rx_dec;

   localparam int CPB = 16;
   localparam int HB  = 8;

   logic       clk;
   logic       nrst;
   logic       uart_dec;
   logic       rx_ready;
   logic       err_clr;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_int;
   logic       busy;
   logic       frame_err;
   logic       overrun;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [7:0] exp_q[$];
   int         exp_cyc_q[$];

   uart_rx_dec #(.CLKS_PER_BIT(CPB), .HALF_BIT(HB)) dut (
      .clk       (clk),
      .nrst      (nrst),
      .uart_dec  (uart_dec),
      .rx_ready  (rx_ready),
      .err_clr   (err_clr),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_int    (rx_int),
      .busy      (busy),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Start bit is driven at cycle N; it reaches rx_s two cycles later, and the
   // byte loads 1+HB+9*CPB cycles after that.
   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic exp_load);
      if (exp_load) begin
         exp_q.push_back(d);
         exp_cyc_q.push_back(cyc + 3 + HB + 9 * CPB);
      end
      uart_dec = 1'b0;
      step(CPB);
      for (int i = 0; i < 8; i++) begin
         uart_dec = d[i];
         step(CPB);
      end
      uart_dec = stop_bit;
      step(CPB);
      uart_dec = 1'b1;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_rx_data"}, {24'd0, rx_data}, 32'h00);
      chk({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
      chk({tag, "_rx_int"}, {31'd0, rx_int}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
      chk({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
   endtask

   initial begin
      logic       fall_pend;
      logic [7:0] e_data;
      int         e_cyc;

      nrst     = 1'b0;
      uart_dec = 1'b1;
      rx_ready = 1'b0;
      err_clr  = 1'b0;
      fall_pend = 1'b0;

      fork
         forever begin
            @(negedge clk);
            if (rx_int) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_rx_int", {31'd0, rx_int}, 32'd0);
               end else begin
                  e_data = exp_q.pop_front();
                  e_cyc  = exp_cyc_q.pop_front();
                  chk("rx_data_at_int", {24'd0, rx_data}, {24'd0, e_data});
                  chk("rx_int_cycle", cyc, e_cyc);
                  chk("rx_valid_at_int", {31'd0, rx_valid}, 32'd1);
               end
            end
            if (fall_pend && !rx_int) begin
               chk("rx_valid_fall", {31'd0, rx_valid}, 32'd0);
            end
            fall_pend = rx_int && rx_ready;
         end
      join_none

      // Reset and long idle
      step(5);
      chk_idle_outputs("in_reset");
      nrst = 1'b1;
      step(2);
      chk_idle_outputs("after_reset");
      step(1000);
      chk_idle_outputs("long_idle");

      // Single frame with consumer always ready
      rx_ready = 1'b1;
      send_frame(8'hA5, 1'b1, 1'b1);
      step(4);
      chk("a5_rx_valid", {31'd0, rx_valid}, 32'd0);
      chk("a5_rx_data", {24'd0, rx_data}, 32'hA5);
      chk("a5_frame_err", {31'd0, frame_err}, 32'd0);
      rx_ready = 1'b0;
      step(5);

      // Short low glitch is rejected in START
      uart_dec = 1'b0;
      step(4);
      chk("glitch_busy_high", {31'd0, busy}, 32'd1);
      uart_dec = 1'b1;
      step(12);
      chk("glitch_busy", {31'd0, busy}, 32'd0);
      chk("glitch_frame_err", {31'd0, frame_err}, 32'd0);
      chk("glitch_overrun", {31'd0, overrun}, 32'd0);
      chk("glitch_rx_valid", {31'd0, rx_valid}, 32'd0);

      // Framing error then clear
      send_frame(8'h3C, 1'b0, 1'b0);
      step(30);
      chk("ferr_set", {31'd0, frame_err}, 32'd1);
      chk("ferr_rx_valid", {31'd0, rx_valid}, 32'd0);
      chk("ferr_rx_data", {24'd0, rx_data}, 32'hA5);
      err_clr = 1'b1;
      step(1);
      err_clr = 1'b0;
      chk("ferr_cleared", {31'd0, frame_err}, 32'd0);
      step(5);

      // Overrun: second byte arrives while the first is unconsumed
      send_frame(8'h11, 1'b1, 1'b1);
      send_frame(8'h22, 1'b1, 1'b0);
      step(10);
      chk("ovr_rx_data", {24'd0, rx_data}, 32'h11);
      chk("ovr_set", {31'd0, overrun}, 32'd1);
      chk("ovr_rx_valid", {31'd0, rx_valid}, 32'd1);
      chk("ovr_frame_err", {31'd0, frame_err}, 32'd0);
      err_clr = 1'b1;
      step(1);
      err_clr = 1'b0;
      chk("ovr_cleared", {31'd0, overrun}, 32'd0);
      step(3);

      // Accept of 0x11 coincides with load of 0x33
      fork
         send_frame(8'h33, 1'b1, 1'b1);
         begin
            step(2 + HB + 9 * CPB);
            rx_ready = 1'b1;
            step(1);
            rx_ready = 1'b0;
         end
      join
      step(3);
      chk("acc_rx_data", {24'd0, rx_data}, 32'h33);
      chk("acc_rx_valid", {31'd0, rx_valid}, 32'd1);
      chk("acc_overrun", {31'd0, overrun}, 32'd0);
      rx_ready = 1'b1;
      step(1);
      rx_ready = 1'b0;
      chk("acc_consumed", {31'd0, rx_valid}, 32'd0);
      step(5);

      // Reset during data bit 4 of 0xFF, then a clean frame
      uart_dec = 1'b0;
      step(CPB);
      uart_dec = 1'b1;
      step(4 * CPB + 6);
      chk("mid_busy", {31'd0, busy}, 32'd1);
      nrst = 1'b0;
      step(1);
      chk_idle_outputs("mid_reset");
      step(3);
      nrst = 1'b1;
      step(5);
      rx_ready = 1'b1;
      send_frame(8'h5A, 1'b1, 1'b1);
      step(20);
      chk("post_reset_rx_data", {24'd0, rx_data}, 32'h5A);
      chk("post_reset_busy", {31'd0, busy}, 32'd0);
      chk("post_reset_flags", {30'd0, frame_err, overrun}, 32'd0);
      chk("scoreboard_drained", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
